// File: rtl/muldiv_mips_if.sv
// Request/response bundle between the execute stage and muldiv_mips.
// The master drives the operation request. The slave returns the busy,
// done and error status together with the HI/LO architectural registers.
interface muldiv_mips_if;
    logic        in_start;
    logic [1:0]  in_op;
    logic        in_is_signed;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        out_busy;
    logic        out_done;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic        out_err;

    modport master (
        output in_start, in_op, in_is_signed, in_1, in_2,
        input  out_busy, out_done, out_hi, out_lo, out_err
    );

    modport slave (
        input  in_start, in_op, in_is_signed, in_1, in_2,
        output out_busy, out_done, out_hi, out_lo, out_err
    );
endinterface

// File: rtl/muldiv_mips.sv
// muldiv_mips: multi-cycle 32-bit multiply/divide unit with HI/LO registers.
//
// MULT: shift-add, one multiplier bit per cycle, 32 iterations.
// DIV: restoring division, one quotient bit per cycle, 32 iterations.
// MTHI/MTLO complete in a single cycle.
// Signed operations iterate on magnitudes. The sign is applied on the commit edge.
//
// Build option MULDIV_DIV_EN: when defined, the restoring divider is compiled in.
// When undefined, DIV reports out_err in one cycle and leaves HI/LO untouched.
module muldiv_mips (
    input  logic          in_clk,
    input  logic          in_rst,
    muldiv_mips_if.slave  bus
);
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    // MULT: {partial product high, multiplier shifting out}.
    // DIV: {partial remainder, dividend shifting into quotient}.
    logic [63:0] acc_reg;
    // Magnitude of the multiplicand (MULT) or the divisor (DIV).
    logic [31:0] opnd_reg;
    logic        neg_q_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;

    logic [31:0] abs_1;
    logic [31:0] abs_2;
    logic        sign_xor;
    logic [32:0] mul_sum;
    logic [63:0] acc_next;
    logic [63:0] prod;
    logic [31:0] commit_hi;
    logic [31:0] commit_lo;

`ifdef MULDIV_DIV_EN
    logic        div_reg;
    logic        neg_r_reg;
    logic [32:0] div_sh;
    logic        div_ok;
    logic [31:0] div_rem;
`endif

    assign bus.out_busy = busy_reg;
    assign bus.out_done = done_reg;
    assign bus.out_hi   = hi_reg;
    assign bus.out_lo   = lo_reg;
    assign bus.out_err  = err_reg;

    // Operand magnitudes and the result sign, taken straight from the request.
    always_comb begin
        abs_1    = (bus.in_is_signed && bus.in_1[31]) ? (32'd0 - bus.in_1) : bus.in_1;
        abs_2    = (bus.in_is_signed && bus.in_2[31]) ? (32'd0 - bus.in_2) : bus.in_2;
        sign_xor = bus.in_is_signed & (bus.in_1[31] ^ bus.in_2[31]);
    end

    // One iteration step and the signed result that would be committed on this edge.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        acc_next  = {mul_sum, acc_reg[31:1]};
        prod      = neg_q_reg ? (64'd0 - acc_next) : acc_next;
        commit_hi = prod[63:32];
        commit_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
        // Restoring step: shift in the next dividend bit, then subtract if it fits.
        div_sh  = acc_reg[63:31];
        div_ok  = (div_sh >= {1'b0, opnd_reg});
        div_rem = div_sh[31:0] - opnd_reg;
        if (div_reg) begin
            acc_next  = div_ok ? {div_rem, acc_reg[30:0], 1'b1} : {acc_reg[62:0], 1'b0};
            commit_lo = neg_q_reg ? (32'd0 - acc_next[31:0])  : acc_next[31:0];
            commit_hi = neg_r_reg ? (32'd0 - acc_next[63:32]) : acc_next[63:32];
        end
`endif
    end

    // Control FSM, iteration datapath and the architectural HI/LO/err registers.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            acc_reg   <= 64'd0;
            opnd_reg  <= 32'd0;
            neg_q_reg <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_reg   <= 1'b0;
            neg_r_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    // New requests are dropped here. They are not queued.
                    cnt_reg <= cnt_reg + 5'd1;
                    acc_reg <= acc_next;
                    if (cnt_reg == 5'd31) begin
                        hi_reg    <= commit_hi;
                        lo_reg    <= commit_lo;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a request. DONE falls back to IDLE otherwise.
                    if (bus.in_start) begin
                        err_reg <= 1'b0;
                        case (bus.in_op)
                            OP_MULT: begin
                                acc_reg   <= {32'd0, abs_2};
                                opnd_reg  <= abs_1;
                                neg_q_reg <= sign_xor;
                                cnt_reg   <= 5'd0;
                                busy_reg  <= 1'b1;
                                state_reg <= RUN;
`ifdef MULDIV_DIV_EN
                                div_reg   <= 1'b0;
`endif
                            end
                            OP_DIV: begin
`ifdef MULDIV_DIV_EN
                                if (bus.in_2 == 32'd0) begin
                                    err_reg   <= 1'b1;
                                    done_reg  <= 1'b1;
                                    state_reg <= DONE;
                                end else begin
                                    acc_reg   <= {32'd0, abs_1};
                                    opnd_reg  <= abs_2;
                                    neg_q_reg <= sign_xor;
                                    neg_r_reg <= bus.in_is_signed & bus.in_1[31];
                                    div_reg   <= 1'b1;
                                    cnt_reg   <= 5'd0;
                                    busy_reg  <= 1'b1;
                                    state_reg <= RUN;
                                end
`else
                                // No divider in this build: report the error immediately.
                                err_reg   <= 1'b1;
                                done_reg  <= 1'b1;
                                state_reg <= DONE;
`endif
                            end
                            OP_MTHI: begin
                                hi_reg    <= bus.in_1;
                                done_reg  <= 1'b1;
                                state_reg <= DONE;
                            end
                            default: begin
                                lo_reg    <= bus.in_1;
                                done_reg  <= 1'b1;
                                state_reg <= DONE;
                            end
                        endcase
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
